flash_read_arbiter: RTL
=======================

Name: flash_read_arbiter

Overview:
- Shares the single-port flash read model between NUM_REQ requesters (e.g. boot fetch path, debug module) using round-robin arbitration.
- Sequences each granted burst into per-beat flash reads on the 1-cycle-latency flash interface (flash_ren/flash_addr/flash_rdata).
- Returns beats on a valid/ready response channel with backpressure, range/alignment checking and an error flag.

Parameters:
- NUM_REQ, 2, number of requesters (>=2)
- ADDR_W, 32, byte address width
- DATA_W, 64, beat width; 8 bytes per beat
- LEN_W, 3, burst length field width; beats = len+1 (1..8)
- FLASH_SIZE, 4194304, flash size in bytes; valid addresses are 0..FLASH_SIZE-1

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_addr  in  NUM_REQ*ADDR_W  packed start byte addresses
- req_len  in  NUM_REQ*LEN_W  packed burst lengths (beats-1)
- resp_valid  out  1  response beat valid
- resp_ready  in  1  response beat accept
- resp_id  out  $clog2(NUM_REQ)  index of the owning requester
- resp_data  out  DATA_W  beat data
- resp_err  out  1  beat error (data forced to 0)
- resp_last  out  1  final beat of the burst
- flash_ren  out  1  flash read enable, sampled by flash on rising edge
- flash_addr  out  32  flash byte address
- flash_rdata  in  DATA_W  flash data, valid the cycle after flash_ren

Behaviour:
- Reset (asynchronous, any time including mid-burst): state IDLE, all outputs 0, beat counter 0, RR pointer = NUM_REQ-1 so requester 0 wins first. No partial response survives reset.
- States: IDLE, ISSUE, CAPT, RESP.
- IDLE: req_ready is combinational, one-hot on the RR winner among req_valid (first valid index after the pointer, circularly). On the handshake, latch id/addr/len, set beat=0, move the pointer to the winner, go ISSUE. No grant is made outside IDLE; the burst is locked to its owner.
- Per-beat address: cur = start + 8*beat, computed in ADDR_W+1 bits so it never wraps.
- Bad beat: start[2:0]!=0 (every beat of the burst bad) or cur+8 > FLASH_SIZE.
- ISSUE, good beat: flash_ren=1, flash_addr=cur[31:0]; go CAPT.
- ISSUE, bad beat: flash_ren=0; load resp_data=0, resp_err=1; go RESP directly.
- CAPT: register flash_rdata into resp_data, resp_err=0; go RESP.
- RESP: resp_valid=1; resp_id/data/err/last are held stable until resp_ready. resp_last=(beat==len).
- RESP with resp_ready and not last: beat+=1, go ISSUE.
- RESP with resp_ready and last: go IDLE.
- flash_ren is high only in ISSUE, for exactly one cycle per good beat. flash_addr is 0 when flash_ren=0.
- Latency: request handshake at cycle T gives flash_ren at T+1 and resp_valid at T+3. With resp_ready held high, throughput is one beat per 3 cycles and the next grant can occur 1 cycle after the last beat handshakes.
- Requests changing while not ready are ignored. Simultaneous valids resolve by RR only. req_valid dropping after grant has no effect.

Decomposition:
- flash_ctrl_pkg holds:
  - state enum {IDLE, ISSUE, CAPT, RESP}
  - BEAT_BYTES=8
  - default FLASH_SIZE
  - response struct {id, data, err, last}
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, pointer, enable; output one-hot grant plus index. Combinational; the pointer register lives in the parent.

Test Plan:
- Reset then req0 addr 0x0 len 0, flash word 0x01f292930010029b: flash_ren at T+1 with addr 0, resp_valid at T+3, data 0x01f292930010029b, id 0, last 1, err 0.
- Both requesters valid continuously with len 0: grants alternate 0,1,0,1; a new grant never occurs while a burst is active.
- req1 addr 0x100 len 3 with resp_ready low for 5 cycles on beat 1: flash addrs 0x100, 0x108, 0x110, 0x118; beat 1 data stable during the stall; last only on beat 3; exactly 4 flash_ren pulses.
- Addr 0x3FFFF8 len 1: beat 0 reads flash; beat 1 has err 1, data 0, and no flash_ren.
- Addr 0x4 len 2: three beats all err 1, zero flash_ren pulses. Addr 0xFFFFFFF8 len 1: err on both beats, no wrap to 0.
- Reset asserted during CAPT of beat 2: outputs immediately 0, state IDLE. The next request from requester 0 is granted first and completes normally.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// Shared types and constants for the flash read arbiter: FSM states,
// beat geometry and the registered response payload.
package flash_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned BEAT_BYTES     = 8;
  localparam int unsigned FLASH_SIZE_DEF = 4194304;

  // Payload fields are sized for up to 16 requesters and 64-bit beats.
  localparam int unsigned RESP_ID_W   = 4;
  localparam int unsigned RESP_DATA_W = 64;

  typedef struct packed {
    logic [RESP_ID_W-1:0]   id;
    logic [RESP_DATA_W-1:0] data;
    logic                   err;
    logic                   last;
  } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after
// the pointer, circularly. The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] k;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((32'(ptr) + i + 32'd1) % NUM_REQ);
      if (en && !found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin share of a 1-cycle-latency flash read port; each granted burst
// is split into per-beat reads and returned on a valid/ready channel.
module flash_read_arbiter
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LEN_W      = 3,
  parameter int unsigned FLASH_SIZE = FLASH_SIZE_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  resp_id,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        resp_err,
  output logic                        resp_last,
  output logic                        flash_ren,
  output logic [31:0]                 flash_addr,
  input  logic [DATA_W-1:0]           flash_rdata
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned AW1  = ADDR_W + 1;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, owner_q, win_idx;
  logic [NUM_REQ-1:0]  grant;
  logic [ADDR_W-1:0]   start_q, win_addr, sel_start;
  logic [LEN_W-1:0]    len_q, beat_q, win_len, sel_beat;
  logic [AW1-1:0]      cur;
  logic                bad_q, bad_d;
  logic                resp_valid_q, flash_ren_q;
  logic [31:0]         flash_addr_q;
  resp_t               resp_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (state_q == IDLE),
    .grant (grant),
    .idx   (win_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|grant) state_d = ISSUE;
      ISSUE:   state_d = bad_q ? RESP : CAPT;
      CAPT:    state_d = RESP;
      RESP:    if (resp_ready) state_d = resp_q.last ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // Address and range check for the beat about to enter ISSUE.
  always_comb begin
    req_ready = grant;
    win_addr  = '0;
    win_len   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_len  = req_len[i*LEN_W +: LEN_W];
      end
    end
    sel_start = (state_q == IDLE) ? win_addr : start_q;
    sel_beat  = (state_q == IDLE) ? '0 : LEN_W'(beat_q + LEN_W'(1));
    cur       = {1'b0, sel_start} + (AW1'(sel_beat) << 3);
    bad_d     = (sel_start[2:0] != 3'b000) ||
                ((cur + AW1'(BEAT_BYTES)) > AW1'(FLASH_SIZE));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q        <= ID_W'(NUM_REQ - 1);
      owner_q      <= '0;
      start_q      <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      bad_q        <= 1'b0;
      flash_ren_q  <= 1'b0;
      flash_addr_q <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      if (state_q == IDLE && |grant) begin
        owner_q <= win_idx;
        start_q <= win_addr;
        len_q   <= win_len;
        beat_q  <= '0;
        ptr_q   <= win_idx;
      end
      if (state_q == RESP && resp_ready && !resp_q.last) beat_q <= LEN_W'(beat_q + LEN_W'(1));
      if (state_d == ISSUE) bad_q <= bad_d;
      flash_ren_q  <= (state_d == ISSUE) && !bad_d;
      flash_addr_q <= ((state_d == ISSUE) && !bad_d) ? 32'(cur) : 32'd0;
      resp_valid_q <= (state_d == RESP);
      if (state_q == ISSUE && bad_q)
        resp_q <= '{id: RESP_ID_W'(owner_q), data: '0, err: 1'b1, last: (beat_q == len_q)};
      else if (state_q == CAPT)
        resp_q <= '{id: RESP_ID_W'(owner_q), data: RESP_DATA_W'(flash_rdata), err: 1'b0,
                    last: (beat_q == len_q)};
      else if (state_q == RESP && resp_ready)
        resp_q <= '0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = ID_W'(resp_q.id);
  assign resp_data  = DATA_W'(resp_q.data);
  assign resp_err   = resp_q.err;
  assign resp_last  = resp_q.last;
  assign flash_ren  = flash_ren_q;
  assign flash_addr = flash_addr_q;

endmodule
